// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner: one column driven low per scan tick, rows synchronized,
// press/release debounced, one key code per press held in a valid/ack register.
module key_matrix_scan #(
   parameter int unsigned SCAN_DIV     = 5000,
   parameter int unsigned DEBOUNCE_CNT = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   localparam int unsigned   TW        = $clog2(SCAN_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e        state_q, state_d;
   logic [3:0]    sync1_q, rs_q;
   logic [TW-1:0] tick_cnt_q;
   logic [1:0]    col_q, col_d;
   logic [7:0]    stable_q, stable_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          overrun_q, overrun_d;
   logic          tick, commit, ack_take;
   logic          row_single;
   logic [1:0]    row_idx;

   assign tick     = (tick_cnt_q == TICK_LAST);
   assign ack_take = key_ack & key_valid_q;

   // Exactly one low row names a key; idle and multi-row (ghost) patterns are both "no key".
   always_comb begin
      row_single = 1'b0;
      row_idx    = 2'd0;
      case (rs_q)
         4'b1110: begin row_single = 1'b1; row_idx = 2'd0; end
         4'b1101: begin row_single = 1'b1; row_idx = 2'd1; end
         4'b1011: begin row_single = 1'b1; row_idx = 2'd2; end
         4'b0111: begin row_single = 1'b1; row_idx = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      stable_d = stable_q;
      cand_d   = cand_q;
      commit   = 1'b0;
      if (tick) begin
         case (state_q)
            StScan: begin
               if (row_single) begin
                  cand_d = {row_idx, col_q};
                  if (DEBOUNCE_CNT == 1) begin
                     commit   = 1'b1;
                     stable_d = 8'd0;
                     state_d  = StHeld;
                  end else begin
                     stable_d = 8'd1;
                     state_d  = StDebounce;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
            StDebounce: begin
               if (row_single && (row_idx == cand_q[3:2])) begin
                  if (stable_q + 8'd1 == DB_LAST) begin
                     commit   = 1'b1;
                     stable_d = 8'd0;
                     state_d  = StHeld;
                  end else begin
                     stable_d = stable_q + 8'd1;
                  end
               end else begin
                  stable_d = 8'd0;
                  col_d    = col_q + 2'd1;
                  state_d  = StScan;
               end
            end
            StHeld: begin
               if (rs_q == 4'hF) begin
                  if (stable_q + 8'd1 == DB_LAST) begin
                     stable_d = 8'd0;
                     col_d    = col_q + 2'd1;
                     state_d  = StScan;
                  end else begin
                     stable_d = stable_q + 8'd1;
                  end
               end else begin
                  stable_d = 8'd0;
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

   // A commit beats a same-cycle ack: the register reloads instead of clearing.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      if (commit && (!key_valid_q || key_ack)) begin
         key_code_d  = cand_d;
         key_valid_d = 1'b1;
      end else if (ack_take) begin
         key_valid_d = 1'b0;
      end
      if (commit && key_valid_q && !key_ack) begin
         overrun_d = 1'b1;
      end else if (ack_take) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StScan;
         sync1_q     <= 4'hF;
         rs_q        <= 4'hF;
         tick_cnt_q  <= '0;
         col_q       <= 2'd0;
         stable_q    <= 8'd0;
         cand_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= row_in;
         rs_q        <= sync1_q;
         tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
         col_q       <= col_d;
         stable_q    <= stable_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign col_out   = ~(4'b0001 << col_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;
   assign key_down  = (state_q == StHeld);

endmodule
